fetcher: RTL
============

# fetcher

Instruction fetch stage of the out-of-order RV32I core. It holds the architectural fetch PC and probes a direct-mapped instruction cache, filling it from the memory controller on a miss. It applies static branch prediction and hands one instruction per cycle to the dispatcher as inst/pc/predicted-jump/rollback-pc. It stalls on back-pressure from ROB/RS/LSB and redirects on ROB rollback.

## Interface
- ICACHE_LINES, 64: number of cache lines; one 32-bit word per line; power of two.
- RESET_PC, 32'h0: PC loaded on reset.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = pause
- full_from_rob / full_from_rs / full_from_lsb  in  1 each  consumer cannot accept; asserted with ≥2 free slots of margin
- rollback_flag_from_rob  in  1  mispredict flush
- target_pc_from_rob  in  32  redirect PC, valid with rollback
- fetch_req_to_memctrl  out  1  word fetch request, level, held until served
- addr_to_memctrl  out  32  word address of request
- ok_flag_from_memctrl  in  1  one-cycle pulse: inst_from_memctrl valid
- inst_from_memctrl  in  32  fetched word
- ok_flag_to_dsp  out  1  one-cycle pulse: instruction issued
- inst_to_dsp / pc_to_dsp  out  32 each  issued instruction and its PC
- predicted_jump_to_dsp  out  1  fetch took the predicted-taken path
- rollback_pc_to_dsp  out  32  PC ROB restores if prediction wrong

## Operation
- Cache: index = pc[log2(L)+1:2], tag = pc[31:log2(L)+2], valid bit per line. Hit = valid & tag match at current pc.
- States: IDLE, WAIT_MEM.
- IDLE, no rollback, no full: hit → issue (register outputs, ok_flag_to_dsp=1, pc ← predicted next). Miss → fetch_req=1, addr=pc, go WAIT_MEM.
- IDLE, any full high: no issue, pc held, no memory request.
- WAIT_MEM: on ok_flag_from_memctrl write data/tag/valid at index of addr_to_memctrl, drop fetch_req, go IDLE. No issue from WAIT_MEM.
- Prediction (opcode of fetched word):
  - JAL 1101111: next = pc+immJ, predicted=1, rollback_pc = pc+4.
  - BRANCH 1100011: immB<0 → next = pc+immB, predicted=1, rollback_pc = pc+4; else next = pc+4, predicted=0, rollback_pc = pc+immB.
  - Others incl. JALR: next = pc+4, predicted=0, rollback_pc = pc+4.
  - Immediates sign-extended to 32; adds modulo 2^32.
- Rollback (highest priority, any state): pc ← target_pc_from_rob, ok_flag_to_dsp=0, fetch_req=0, state IDLE. Memory response in the same cycle is still written to cache (data correct for its address), never issued. Memctrl drops pending requests when req falls.
- rdy low: no state change; only ok_flag_to_dsp clears to 0.
- Reset: pc=RESET_PC, state IDLE, all valid bits 0, ok_flag_to_dsp=0, fetch_req_to_memctrl=0, addr_to_memctrl=0, inst/pc/rollback_pc_to_dsp=0, predicted_jump_to_dsp=0. Reset mid-fill abandons the request.

## Timing
- Hit: issue at the edge after pc presented; back-to-back hits give 1 instr/cycle.
- Miss: fetch_req rises at edge N+1 after miss at N; fill at edge of ok pulse; state IDLE then hit issue one edge later → miss penalty = memctrl latency + 2 cycles.
- full sampled combinationally each cycle; rises → no issue at that edge.
- Rollback at edge R: first instruction from target issued earliest at R+1 (hit).
- ok_flag_to_dsp never high two cycles for the same pc unless rollback re-targets it.

## Test plan
- Reset, cache cold, RESET_PC=0, memctrl latency 3 returning 32'h00100093 (addi): fetch_req/addr=0 → fill → ok_flag_to_dsp pulse with inst=32'h00100093, pc=0, predicted=0, rollback_pc=4; next pc=4.
- Loop body at 0x10..0x18, backward branch at 0x18 with immB=-8, cache warm: issues 0x10,0x14,0x18,0x10 consecutively; at 0x18 predicted=1, rollback_pc=0x1C.
- JAL at 0x20, immJ=+0x40: predicted=1, next issued pc=0x60; forward BEQ immB=+12 at 0x60: predicted=0, rollback_pc=0x6C.
- full_from_rs high 3 cycles during hit stream: no ok pulses for 3 cycles, pc frozen, resumes with same pc, no skipped or duplicated instruction.
- Rollback with target 0x200 in WAIT_MEM for 0x80, memctrl ok in same cycle: no issue, line for 0x80 valid, fetch_req drops, next request addr=0x200.
- rdy low 2 cycles mid-stream then high: ok_flag 0 while low, stream continues at same pc; rst mid-fill → all outputs reset values, valid bits cleared.

Source files
------------

// File: rtl/fetcher.sv
// fetcher: instruction fetch stage with a direct-mapped I-cache and static branch prediction.
// Issues one instruction per cycle on a hit; refills a single word from memctrl on a miss.
module fetcher #(
   parameter int          ICACHE_LINES = 64,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        full_from_rob,
   input  logic        full_from_rs,
   input  logic        full_from_lsb,
   input  logic        rollback_flag_from_rob,
   input  logic [31:0] target_pc_from_rob,
   output logic        fetch_req_to_memctrl,
   output logic [31:0] addr_to_memctrl,
   input  logic        ok_flag_from_memctrl,
   input  logic [31:0] inst_from_memctrl,
   output logic        ok_flag_to_dsp,
   output logic [31:0] inst_to_dsp,
   output logic [31:0] pc_to_dsp,
   output logic        predicted_jump_to_dsp,
   output logic [31:0] rollback_pc_to_dsp
);
   localparam int IW = $clog2(ICACHE_LINES);
   localparam int TW = 30 - IW;
   typedef enum logic {IDLE, WAIT_MEM} state_t;
   state_t state, state_nx;
   logic [31:0] pc, pc_nx, addr_nx;
   logic req_nx;
   logic [31:0] data [ICACHE_LINES];
   logic [TW-1:0] tags [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] valid;
   logic [IW-1:0] idx, fill_idx;
   logic hit, full, fill, issue, is_jal, is_br, taken;
   logic [31:0] cur, imm_j, imm_b, pred_pc, rb_pc;
   assign idx      = pc[IW+1:2];
   assign fill_idx = addr_to_memctrl[IW+1:2];
   assign cur      = data[idx];
   assign hit      = valid[idx] && tags[idx] == pc[31:IW+2];
   assign full     = full_from_rob || full_from_rs || full_from_lsb;
   // a response that races a rollback is still a correct word for its address, so keep it
   assign fill     = rdy && state == WAIT_MEM && ok_flag_from_memctrl;
   assign issue    = rdy && !rollback_flag_from_rob && state == IDLE && !full && hit;
   assign imm_j    = {{12{cur[31]}}, cur[19:12], cur[20], cur[30:21], 1'b0};
   assign imm_b    = {{20{cur[31]}}, cur[7], cur[30:25], cur[11:8], 1'b0};
   assign is_jal   = cur[6:0] == 7'b1101111;
   assign is_br    = cur[6:0] == 7'b1100011;
   assign taken    = is_jal || (is_br && imm_b[31]);
   assign pred_pc  = pc + (is_jal ? imm_j : taken ? imm_b : 32'd4);
   assign rb_pc    = pc + ((is_br && !imm_b[31]) ? imm_b : 32'd4);
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      req_nx   = fetch_req_to_memctrl;
      addr_nx  = addr_to_memctrl;
      if (rdy && rollback_flag_from_rob) begin
         state_nx = IDLE;
         pc_nx    = target_pc_from_rob;
         req_nx   = 1'b0;
      end else if (fill) begin
         state_nx = IDLE;
         req_nx   = 1'b0;
      end else if (issue) begin
         pc_nx = pred_pc;
      end else if (rdy && state == IDLE && !full) begin
         state_nx = WAIT_MEM;
         req_nx   = 1'b1;
         addr_nx  = pc;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         pc                    <= RESET_PC;
         valid                 <= '0;
         fetch_req_to_memctrl  <= 1'b0;
         addr_to_memctrl       <= 32'h0;
         ok_flag_to_dsp        <= 1'b0;
         inst_to_dsp           <= 32'h0;
         pc_to_dsp             <= 32'h0;
         predicted_jump_to_dsp <= 1'b0;
         rollback_pc_to_dsp    <= 32'h0;
      end else begin
         state                <= state_nx;
         pc                   <= pc_nx;
         fetch_req_to_memctrl <= req_nx;
         addr_to_memctrl      <= addr_nx;
         ok_flag_to_dsp       <= issue;
         if (fill) valid[fill_idx] <= 1'b1;
         if (issue) begin
            inst_to_dsp           <= cur;
            pc_to_dsp             <= pc;
            predicted_jump_to_dsp <= taken;
            rollback_pc_to_dsp    <= rb_pc;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (fill) begin
         data[fill_idx] <= inst_from_memctrl;
         tags[fill_idx] <= addr_to_memctrl[31:IW+2];
      end
   end
endmodule
